// File: rtl/pll_reset_sequencer.sv
// PLL areset / lock sequencer with Avalon-MM control and status registers.
// Optional irq output is enabled by defining PLL_RESET_SEQUENCER_IRQ_EN.
module pll_reset_sequencer #(
   parameter int unsigned NUM_CLK       = 4,
   parameter int unsigned AR_CYCLES     = 16,
   parameter int unsigned STABLE_CYCLES = 64,
   parameter int unsigned LOCK_TIMEOUT  = 4096,
   parameter int unsigned CNT_W         = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               read,
   input  logic               write,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   output logic               pll_areset,
   input  logic               pll_locked,
   output logic [NUM_CLK-1:0] clk_ena,
`ifdef PLL_RESET_SEQUENCER_IRQ_EN
   output logic               irq,
`endif
   output logic               resetrequest
);

   typedef enum logic [1:0] {
      StHold   = 2'd0,
      StWait   = 2'd1,
      StStable = 2'd2,
      StRun    = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(AR_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e               r_state, w_state_d;
   logic [CNT_W-1:0]     r_cnt, w_cnt_d;
   logic                 r_sync1, r_sync2;
   logic                 r_lost, r_timeout, r_auto;
   logic [7:0]           r_retry;
   logic [NUM_CLK-1:0]   r_mask, w_mask_d;
   logic                 r_areset, r_rstreq;
   logic [NUM_CLK-1:0]   r_clk_ena;
   logic                 w_areset_d, w_rstreq_d;
   logic [NUM_CLK-1:0]   w_clk_ena_d;
   logic                 w_wr, w_restart, w_clr_lost, w_clr_timeout;
   logic                 w_lost_set, w_timeout_set;
   logic                 w_irq_en;
   logic                 w_unused;

   assign w_wr          = chipselect & write;
   assign w_restart     = w_wr && (address == 3'd1) && writedata[0];
   assign w_clr_lost    = w_wr && (address == 3'd2) && writedata[4];
   assign w_clr_timeout = w_wr && (address == 3'd2) && writedata[5];
   assign w_mask_d      = (w_wr && (address == 3'd3)) ? writedata[NUM_CLK-1:0] : r_mask;
   assign w_unused      = ^{read, writedata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StHold;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt + CNT_ONE;
      w_lost_set    = 1'b0;
      w_timeout_set = 1'b0;
      case (r_state)
         StHold: begin
            if (r_cnt == AR_LAST) begin
               w_state_d = StWait;
               w_cnt_d   = '0;
            end
         end
         StWait: begin
            if (r_sync2) begin
               w_state_d = StStable;
               w_cnt_d   = '0;
            end else if (r_cnt == TO_LAST) begin
               w_timeout_set = 1'b1;
               w_state_d     = StHold;
               w_cnt_d       = '0;
            end
         end
         StStable: begin
            if (!r_sync2) begin
               w_state_d = StWait;
               w_cnt_d   = '0;
            end else if (r_cnt == ST_LAST) begin
               w_state_d = StRun;
               w_cnt_d   = '0;
            end
         end
         StRun: begin
            w_cnt_d = '0;
            if (!r_sync2) begin
               w_lost_set = 1'b1;
               w_state_d  = r_auto ? StHold : StWait;
            end
         end
         default: begin
            w_state_d = StHold;
            w_cnt_d   = '0;
         end
      endcase
      // Restart overrides every transition, including lock loss
      if (w_restart) begin
         w_state_d = StHold;
         w_cnt_d   = '0;
      end
   end

   // Outputs are registered from the next state so they line up with r_state
   always_comb begin
      w_areset_d  = (w_state_d == StHold);
      w_rstreq_d  = (w_state_d != StRun);
      w_clk_ena_d = (w_state_d == StRun) ? w_mask_d : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_areset  <= 1'b1;
         r_rstreq  <= 1'b1;
         r_clk_ena <= '0;
         r_mask    <= '1;
         r_lost    <= 1'b0;
         r_timeout <= 1'b0;
         r_auto    <= 1'b1;
         r_retry   <= 8'd0;
      end else begin
         r_sync1   <= pll_locked;
         r_sync2   <= r_sync1;
         r_areset  <= w_areset_d;
         r_rstreq  <= w_rstreq_d;
         r_clk_ena <= w_clk_ena_d;
         r_mask    <= w_mask_d;
         r_lost    <= w_lost_set | (r_lost & ~w_clr_lost);
         r_timeout <= w_timeout_set | (r_timeout & ~w_clr_timeout);
         if (w_wr && (address == 3'd1)) begin
            r_auto <= writedata[1];
         end
         if (w_restart) begin
            r_retry <= 8'd0;
         end else if (w_timeout_set && (r_retry != 8'hFF)) begin
            r_retry <= r_retry + 8'd1;
         end
      end
   end

`ifdef PLL_RESET_SEQUENCER_IRQ_EN
   logic r_irq_en, r_irq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && (address == 3'd1)) begin
            r_irq_en <= writedata[2];
         end
         r_irq <= r_irq_en & (r_lost | r_timeout);
      end
   end

   assign w_irq_en = r_irq_en;
   assign irq      = r_irq;
`else
   assign w_irq_en = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         3'd0:    readdata = {10'd0, r_timeout, r_lost, 2'(r_state), (r_state == StRun), r_sync2};
         3'd1:    readdata = {13'd0, w_irq_en, r_auto, 1'b0};
         3'd3:    readdata[NUM_CLK-1:0] = r_mask;
         3'd4:    readdata = {8'd0, r_retry};
         default: readdata = '0;
      endcase
   end

   assign pll_areset   = r_areset;
   assign resetrequest = r_rstreq;
   assign clk_ena      = r_clk_ena;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer against a behavioural sequencing model.
module tb_pll_reset_sequencer;

   localparam int NCLK = 4;
   localparam int AR   = 16;
   localparam int ST   = 64;
   localparam int TO   = 100;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [2:0]      address;
   logic            chipselect, read, write;
   logic [15:0]     writedata;
   logic [15:0]     readdata;
   logic            pll_areset, pll_locked, resetrequest;
   logic [NCLK-1:0] clk_ena;
`ifdef PLL_RESET_SEQUENCER_IRQ_EN
   logic            irq;
`endif

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .NUM_CLK      (NCLK),
      .AR_CYCLES    (AR),
      .STABLE_CYCLES(ST),
      .LOCK_TIMEOUT (TO),
      .CNT_W        (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .read        (read),
      .write       (write),
      .writedata   (writedata),
      .readdata    (readdata),
      .pll_areset  (pll_areset),
      .pll_locked  (pll_locked),
      .clk_ena     (clk_ena),
`ifdef PLL_RESET_SEQUENCER_IRQ_EN
      .irq         (irq),
`endif
      .resetrequest(resetrequest)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Behavioural model: phase 0=hold,1=wait-lock,2=stable,3=run
   int         m_phase, m_cnt, m_retry;
   bit         m_lost, m_to, m_auto, m_irq_en, m_irq;
   logic [3:0] m_mask;
   bit         lkq[$];   // lkq[0] is the lock value the sequencer currently acts on

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_retry = 0;
      m_lost = 0; m_to = 0; m_auto = 1; m_irq_en = 0; m_irq = 0;
      m_mask = 4'hF;
      lkq = '{1'b0, 1'b0};
   endtask

   task automatic model_step();
      bit wr, lk, restart, lost_set, to_set, irq_nx;
      int nphase, ncnt;
      wr      = chipselect && write;
      lk      = lkq[0];
      restart = wr && address == 3'd1 && writedata[0];
      irq_nx  = m_irq_en && (m_lost || m_to);
      lost_set = 0; to_set = 0;
      nphase = m_phase; ncnt = m_cnt + 1;
      if (m_phase == 0) begin
         if (m_cnt == AR - 1) begin nphase = 1; ncnt = 0; end
      end else if (m_phase == 1) begin
         if (lk) begin nphase = 2; ncnt = 0; end
         else if (m_cnt == TO - 1) begin to_set = 1; nphase = 0; ncnt = 0; end
      end else if (m_phase == 2) begin
         if (!lk) begin nphase = 1; ncnt = 0; end
         else if (m_cnt == ST - 1) begin nphase = 3; ncnt = 0; end
      end else begin
         ncnt = 0;
         if (!lk) begin lost_set = 1; nphase = m_auto ? 0 : 1; end
      end
      if (restart) begin nphase = 0; ncnt = 0; end
      m_phase = nphase; m_cnt = ncnt;
      if (restart) m_retry = 0;
      else if (to_set && m_retry < 255) m_retry++;
      m_lost = lost_set || (m_lost && !(wr && address == 3'd2 && writedata[4]));
      m_to   = to_set || (m_to && !(wr && address == 3'd2 && writedata[5]));
      if (wr && address == 3'd1) begin
         m_auto = writedata[1];
`ifdef PLL_RESET_SEQUENCER_IRQ_EN
         m_irq_en = writedata[2];
`endif
      end
      if (wr && address == 3'd3) m_mask = writedata[3:0];
      m_irq = irq_nx;
      lkq.push_back(pll_locked);
      void'(lkq.pop_front());
   endtask

   function automatic logic [15:0] exp_read(input logic [2:0] a);
      logic [15:0] e;
      logic [7:0]  r8;
      logic [1:0]  p2;
      e = '0;
      r8 = 8'(m_retry);
      p2 = 2'(m_phase);
      case (a)
         3'd0: begin
            e[0] = lkq[0]; e[1] = (m_phase == 3); e[3:2] = p2; e[4] = m_lost; e[5] = m_to;
         end
         3'd1: begin e[1] = m_auto; e[2] = m_irq_en; end
         3'd3: e[3:0] = m_mask;
         3'd4: e[7:0] = r8;
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic check_all();
      check_eq("pll_areset", 16'(pll_areset), 16'(m_phase == 0));
      check_eq("resetrequest", 16'(resetrequest), 16'(m_phase != 3));
      check_eq("clk_ena", 16'(clk_ena), (m_phase == 3) ? 16'(m_mask) : 16'h0);
      check_eq("readdata", readdata, exp_read(address));
`ifdef PLL_RESET_SEQUENCER_IRQ_EN
      check_eq("irq", 16'(irq), 16'(m_irq));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      #1;
      cyc++;
      check_all();
      @(negedge clk);
   endtask

   task automatic idle_tick();
      address    = 3'($urandom_range(0, 7));
      read       = 1'($urandom);
      chipselect = 1'($urandom);
      write      = !chipselect && 1'($urandom);
      writedata  = 16'($urandom);
      tick();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int fall_ar, fall_rr, e0, seg;
      reset_n = 1'b0; pll_locked = 1'b0; address = 3'd1;
      chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_all();
      check_eq("rst_areset", 16'(pll_areset), 16'h1);
      check_eq("rst_rstreq", 16'(resetrequest), 16'h1);
      check_eq("rst_ctrl", readdata, 16'h0002);

      // Power-up with lock arriving at edge 30
      reset_n = 1'b1;
      cyc = 0; fall_ar = -1; fall_rr = -1;
      for (int i = 0; i < 120; i++) begin
         pll_locked = (cyc >= 29);
         idle_tick();
         if (!pll_areset && fall_ar < 0) fall_ar = cyc;
         if (!resetrequest && fall_rr < 0) fall_rr = cyc;
      end
      check_eq("pu_areset_fall", 16'(fall_ar), 16'd16);
      check_eq("pu_rstreq_fall", 16'(fall_rr), 16'd96);
      check_eq("pu_clk_ena", 16'(clk_ena), 16'h000F);

      // Lock loss in RUN with auto_relock off
      bus_write(3'd1, 16'h0000);
      pll_locked = 1'b0;
      address = 3'd0;
      repeat (3) tick();
      check_eq("loss_rstreq", 16'(resetrequest), 16'h1);
      check_eq("loss_clk_ena", 16'(clk_ena), 16'h0);
      check_eq("loss_status", readdata & 16'h001E, 16'h0014);
      check_eq("loss_areset", 16'(pll_areset), 16'h0);
      bus_write(3'd2, 16'h0010);
      address = 3'd0;
      tick();
      check_eq("loss_clear", readdata & 16'h0010, 16'h0);

      // Relock, mask write, then restart
      pll_locked = 1'b1;
      repeat (80) idle_tick();
      bus_write(3'd3, 16'h0005);
      check_eq("mask_clk_ena", 16'(clk_ena), 16'h0005);
      bus_write(3'd1, 16'h0003);
      check_eq("rs_areset", 16'(pll_areset), 16'h1);
      check_eq("rs_clk_ena", 16'(clk_ena), 16'h0);
      address = 3'd1;
      tick();
      check_eq("rs_ctrl", readdata, 16'h0002);

      // Timeouts with lock held low
      pll_locked = 1'b0;
      repeat (3) idle_tick();
      bus_write(3'd1, 16'h0003);
      address = 3'd4;
      e0 = cyc;
      while (cyc - e0 < 350) tick();
      check_eq("to_retry", readdata, 16'h0003);
      address = 3'd0;
      tick();
      check_eq("to_sticky", readdata & 16'h0020, 16'h0020);

`ifdef PLL_RESET_SEQUENCER_IRQ_EN
      bus_write(3'd2, 16'h0030);
      bus_write(3'd1, 16'h0006);
      repeat (130) tick();
      check_eq("irq_set", 16'(irq), 16'h1);
      bus_write(3'd2, 16'h0030);
      tick();
      check_eq("irq_clear", 16'(irq), 16'h0);
`endif

      // Mid-sequence asynchronous reset
      repeat (7) idle_tick();
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      check_eq("mid_rst_areset", 16'(pll_areset), 16'h1);
      @(negedge clk);
      reset_n = 1'b1;

      // Random lock segments and bus traffic
      seg = 0;
      for (int i = 0; i < 3000; i++) begin
         if (seg == 0) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            seg = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 8))
                                              : int'($urandom_range(20, 250));
         end
         seg--;
         if ($urandom_range(0, 99) < 4) begin
            bus_write(3'($urandom_range(0, 7)), 16'($urandom));
         end else begin
            idle_tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
